// File: rtl/clk_ratio_pkg.sv
// Shared types and sizing helpers for the clock ratio meter.
// Pure definitions: no latency, no flow control.
package clk_ratio_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    localparam int MEAS_CNT_W = 16;

    // Right-shift that turns an accumulated sum into an average.
    function automatic int log2_periods(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Index width able to hold the value n itself.
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronizes an async level and flags its rising edge; SYNC_STAGES cycles to level_o.
// Latency fixed; no backpressure, every edge seen by the sync chain is reported once.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_l,
    input  logic d_in,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Averages clk cycles per ref_in period over NUM_PERIODS periods; result valid the cycle after the closing edge.
// Result is held in DONE until ratio_ready_i; reference edges arriving while held are ignored.
module clk_ratio_meter
    import clk_ratio_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int NUM_PERIODS = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  enable,
    input  logic                  ref_in,
    output logic [CNT_W-1:0]      ratio_o,
    output logic                  ratio_valid_o,
    input  logic                  ratio_ready_i,
    output logic                  overflow_o,
    output logic                  busy_o,
    output logic [MEAS_CNT_W-1:0] meas_count_o
);

    localparam int               LOG2_N  = log2_periods(NUM_PERIODS);
    localparam int               ACC_W   = CNT_W + LOG2_N;
    localparam int               IDX_W   = idx_width(NUM_PERIODS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    sat_q, sat_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        ratio_q, ratio_d;
    logic                    valid_q, valid_d;
    logic [MEAS_CNT_W-1:0]   meas_q, meas_d;

    logic                    ref_level_unused;
    logic                    ref_rise;
    logic                    cnt_at_max;
    logic [IDX_W-1:0]        idx_inc;
    logic [ACC_W-1:0]        acc_sum;

    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_l (reset_l),
        .d_in    (ref_in),
        .level_o (ref_level_unused),
        .rise_o  (ref_rise)
    );

    assign cnt_at_max = (cnt_q == CNT_MAX);
    assign idx_inc    = idx_q + IDX_W'(1);
    assign acc_sum    = acc_q + ACC_W'(cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;
        ratio_d = ratio_q;
        valid_d = valid_q;
        meas_d  = meas_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                acc_d = '0;
                idx_d = '0;
                sat_d = 1'b0;
                ovf_d = 1'b0;
                state_d = ARM;
            end
            ARM: begin
                if (ref_rise) begin
                    cnt_d   = CNT_W'(1);
                    acc_d   = '0;
                    idx_d   = '0;
                    sat_d   = 1'b0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (cnt_at_max) begin
                    sat_d = 1'b1;
                    ovf_d = 1'b1;
                end
                if (ref_rise) begin
                    if (idx_inc == IDX_W'(NUM_PERIODS)) begin
                        // A single saturated period makes the average meaningless.
                        ratio_d = (sat_q || cnt_at_max) ? CNT_MAX
                                                        : CNT_W'(acc_sum >> LOG2_N);
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = CNT_W'(1);
                        idx_d = idx_inc;
                    end
                end else if (!cnt_at_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (valid_q && ratio_ready_i) begin
                    valid_d = 1'b0;
                    meas_d  = meas_q + MEAS_CNT_W'(1);
                    state_d = ARM;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything: partial or held results are dropped uncounted.
        if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ratio_d = ratio_q;
            meas_d  = meas_q;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ratio_q <= '0;
            valid_q <= 1'b0;
            meas_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            ratio_q <= ratio_d;
            valid_q <= valid_d;
            meas_q  <= meas_d;
        end
    end

    assign ratio_o       = ratio_q;
    assign ratio_valid_o = valid_q;
    assign overflow_o    = ovf_q;
    assign busy_o        = (state_q == ARM) || (state_q == MEASURE);
    assign meas_count_o  = meas_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Bench for clk_ratio_meter: a default instance and a narrow single-period instance share ref_in.
// Expected ratios come from the list of periods the generator was asked to produce.
module tb_clk_ratio_meter;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        ref_in;
    logic        enable_a, ready_a, valid_a, ovf_a, busy_a;
    logic [31:0] ratio_a;
    logic [15:0] count_a;
    logic        enable_b, ready_b, valid_b, ovf_b, busy_b;
    logic [7:0]  ratio_b;
    logic [15:0] count_b;

    int checks = 0;
    int errors = 0;

    int per_q[$];
    int free_per = 0;
    bit gen_busy = 1'b0;

    always #5 clk = ~clk;

    clk_ratio_meter u_a (
        .clk           (clk),
        .reset_l       (reset_l),
        .enable        (enable_a),
        .ref_in        (ref_in),
        .ratio_o       (ratio_a),
        .ratio_valid_o (valid_a),
        .ratio_ready_i (ready_a),
        .overflow_o    (ovf_a),
        .busy_o        (busy_a),
        .meas_count_o  (count_a)
    );

    clk_ratio_meter #(
        .CNT_W       (8),
        .NUM_PERIODS (1),
        .SYNC_STAGES (2)
    ) u_b (
        .clk           (clk),
        .reset_l       (reset_l),
        .enable        (enable_b),
        .ref_in        (ref_in),
        .ratio_o       (ratio_b),
        .ratio_valid_o (valid_b),
        .ratio_ready_i (ready_b),
        .overflow_o    (ovf_b),
        .busy_o        (busy_b),
        .meas_count_o  (count_b)
    );

    // Each entry is one full reference period starting with a rising edge.
    initial begin
        ref_in = 1'b0;
        forever begin
            int p;
            if (per_q.size() != 0) p = per_q.pop_front();
            else                   p = free_per;
            if (p >= 2) begin
                gen_busy = 1'b1;
                ref_in   = 1'b1;
                repeat (p / 2) @(negedge clk);
                ref_in   = 1'b0;
                repeat (p - p / 2) @(negedge clk);
            end else begin
                gen_busy = 1'b0;
                @(negedge clk);
            end
        end
    end

    function automatic longint exp_ratio(input int pers[$], input int n, input int w);
        longint sum  = 0;
        longint maxv = (longint'(1) << w) - 1;
        for (int i = 0; i < n; i++) begin
            if (pers[i] >= maxv) return maxv;
            sum += pers[i];
        end
        return sum / n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_meas(input int pers[$]);
        foreach (pers[i]) per_q.push_back(pers[i]);
        per_q.push_back(6);
    endtask

    task automatic wait_valid(input bit sel_b, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = sel_b ? valid_b : valid_a;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = !gen_busy && (per_q.size() == 0);
        end
    endtask

    initial begin
        bit     ok;
        int     pers[$];
        int     exp_cnt_a;
        int     exp_cnt_b;
        int     vseen;
        longint er;

        reset_l  = 1'b0;
        enable_a = 1'b0;
        ready_a  = 1'b0;
        enable_b = 1'b0;
        ready_b  = 1'b0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        repeat (3) @(negedge clk);
        check("rst_ratio", ratio_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_ovf",   ovf_a,   0);
        check("rst_busy",  busy_a,  0);
        check("rst_count", count_a, 0);
        reset_l = 1'b1;
        @(negedge clk);

        // Free-running period 10, single result held with ready low.
        enable_a = 1'b1;
        free_per = 10;
        wait_valid(1'b0, 300, ok);
        check("t1_timeout", ok, 1);
        check("t1_ratio", ratio_a, 10);
        check("t1_ovf",   ovf_a,   0);
        check("t1_busy",  busy_a,  0);
        check("t1_count", count_a, 0);
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(negedge clk);
            check("hold_ratio", ratio_a, 10);
            check("hold_valid", valid_a, 1);
            check("hold_count", count_a, 0);
        end
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        exp_cnt_a = 1;
        check("accept_valid", valid_a, 0);
        check("accept_count", count_a, exp_cnt_a);

        // Ready held high: consecutive results, each counted once.
        ready_a = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_valid(1'b0, 300, ok);
            check("t3_timeout", ok, 1);
            check("t3_ratio", ratio_a, 10);
            @(negedge clk);
            exp_cnt_a++;
            check("t3_count", count_a, exp_cnt_a);
        end
        ready_a  = 1'b0;
        free_per = 0;
        enable_a = 1'b0;
        wait_idle(200, ok);
        check("gen_idle", ok, 1);

        // Directed alternating periods, then random period sets.
        enable_a = 1'b1;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            pers.delete();
            for (int i = 0; i < 4; i++)
                pers.push_back((r == 0) ? ((i % 2 == 0) ? 8 : 12) : int'($urandom_range(2, 40)));
            er = exp_ratio(pers, 4, 32);
            push_meas(pers);
            wait_valid(1'b0, 400, ok);
            check("rnd_timeout", ok, 1);
            check("rnd_ratio", ratio_a, er);
            check("rnd_ovf", ovf_a, 0);
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
            exp_cnt_a++;
            check("rnd_count", count_a, exp_cnt_a);
        end

        // Disable while a result is held: dropped without counting.
        pers = '{14, 6, 22, 9};
        push_meas(pers);
        wait_valid(1'b0, 400, ok);
        check("drop_timeout", ok, 1);
        check("drop_ratio", ratio_a, exp_ratio(pers, 4, 32));
        enable_a = 1'b0;
        @(negedge clk);
        check("drop_valid", valid_a, 0);
        check("drop_busy",  busy_a,  0);
        check("drop_count", count_a, exp_cnt_a);
        wait_idle(200, ok);
        check("gen_idle2", ok, 1);

        // Asynchronous reset in the middle of a measurement.
        enable_a = 1'b1;
        repeat (3) @(negedge clk);
        pers = '{20, 20, 20, 20};
        push_meas(pers);
        repeat (50) @(negedge clk);
        check("pre_rst_busy", busy_a, 1);
        #2 reset_l = 1'b0;
        #1;
        check("mid_rst_ratio", ratio_a, 0);
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_busy",  busy_a,  0);
        check("mid_rst_count", count_a, 0);
        enable_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        exp_cnt_a = 0;
        wait_idle(200, ok);
        check("gen_idle3", ok, 1);
        check("post_rst_valid", valid_a, 0);
        enable_a = 1'b1;
        repeat (3) @(negedge clk);
        pers.delete();
        for (int i = 0; i < 4; i++) pers.push_back(int'($urandom_range(2, 40)));
        push_meas(pers);
        wait_valid(1'b0, 400, ok);
        check("post_rst_timeout", ok, 1);
        check("post_rst_ratio", ratio_a, exp_ratio(pers, 4, 32));
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        exp_cnt_a++;
        check("post_rst_count", count_a, exp_cnt_a);

        // Disable in the middle of a measurement: no result pulse.
        pers = '{20, 20, 20, 20};
        push_meas(pers);
        repeat (50) @(negedge clk);
        enable_a = 1'b0;
        @(negedge clk);
        check("dis_busy", busy_a, 0);
        vseen = 0;
        for (int i = 0; i < 200 && (gen_busy || per_q.size() != 0); i++) begin
            @(negedge clk);
            if (valid_a) vseen++;
        end
        check("dis_no_valid", vseen, 0);
        check("dis_count", count_a, exp_cnt_a);

        // Narrow instance: single-period results and counter saturation.
        enable_b = 1'b1;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            pers.delete();
            pers.push_back((r == 0) ? 8 : (r == 1) ? 12 : int'($urandom_range(2, 200)));
            push_meas(pers);
            wait_valid(1'b1, 400, ok);
            check("b_timeout", ok, 1);
            check("b_ratio", ratio_b, exp_ratio(pers, 1, 8));
            check("b_ovf", ovf_b, 0);
            ready_b = 1'b1;
            @(negedge clk);
            ready_b = 1'b0;
            exp_cnt_b++;
            check("b_count", count_b, exp_cnt_b);
        end
        pers = '{300};
        push_meas(pers);
        wait_valid(1'b1, 800, ok);
        check("sat_timeout", ok, 1);
        check("sat_ratio", ratio_b, exp_ratio(pers, 1, 8));
        check("sat_ovf", ovf_b, 1);
        enable_b = 1'b0;
        @(negedge clk);
        enable_b = 1'b1;
        check("sat_drop_valid", valid_b, 0);
        check("sat_drop_busy",  busy_b,  0);
        @(negedge clk);
        check("sat_clear_ovf", ovf_b, 0);
        check("sat_count", count_b, exp_cnt_b);
        enable_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
